// File: rtl/cpu_defines_pkg.sv
// Shared definitions for the execute stage: ALU select/op encodings,
// the generic zero word and the mul/div FSM state type.
package cpu_defines_pkg;

    localparam int ALUSEL_W = 3;
    localparam int ALUOP_W  = 5;

    typedef logic [ALUSEL_W-1:0] AluSelBus;
    typedef logic [ALUOP_W-1:0]  AluOpBus;

    // Result classes; encodings 5..7 are unused and give a zero result.
    localparam AluSelBus SEL_NOP   = 3'd0;
    localparam AluSelBus SEL_LOGIC = 3'd1;
    localparam AluSelBus SEL_SHIFT = 3'd2;
    localparam AluSelBus SEL_ARITH = 3'd3;
    localparam AluSelBus SEL_MOVE  = 3'd4;

    // Operation codes.
    localparam AluOpBus OP_NOP   = 5'd0;
    localparam AluOpBus OP_OR    = 5'd1;
    localparam AluOpBus OP_AND   = 5'd2;
    localparam AluOpBus OP_XOR   = 5'd3;
    localparam AluOpBus OP_NOR   = 5'd4;
    localparam AluOpBus OP_SLL   = 5'd5;
    localparam AluOpBus OP_SRL   = 5'd6;
    localparam AluOpBus OP_SRA   = 5'd7;
    localparam AluOpBus OP_ADD   = 5'd8;
    localparam AluOpBus OP_ADDU  = 5'd9;
    localparam AluOpBus OP_SUB   = 5'd10;
    localparam AluOpBus OP_SUBU  = 5'd11;
    localparam AluOpBus OP_SLT   = 5'd12;
    localparam AluOpBus OP_SLTU  = 5'd13;
    localparam AluOpBus OP_MFHI  = 5'd14;
    localparam AluOpBus OP_MFLO  = 5'd15;
    localparam AluOpBus OP_MTHI  = 5'd16;
    localparam AluOpBus OP_MTLO  = 5'd17;
    localparam AluOpBus OP_MULT  = 5'd18;
    localparam AluOpBus OP_MULTU = 5'd19;
    localparam AluOpBus OP_DIV   = 5'd20;
    localparam AluOpBus OP_DIVU  = 5'd21;

    // Zero word, sliced down to the datapath width by the user.
    localparam int MAX_DATA_W = 64;
    localparam logic [MAX_DATA_W-1:0] ZeroWord = '0;

    // Mul/div sequencer states.
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    function automatic logic is_muldiv(input AluOpBus op);
        return (op == OP_MULT) || (op == OP_MULTU) ||
               (op == OP_DIV)  || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit. Owns HI/LO. One bit per cycle:
// shift-add for multiply, restoring division for divide. Operands are
// reduced to magnitudes at issue and the signs are applied in DONE.
//
// Handshake: start_i is sampled only in IDLE; busy_o is high in the issue
// cycle and through MUL/DIV, low in DONE and whenever flush_i is high. The
// issuer must hold start_i and the operands stable while busy_o is high.
module mdu_iter
    import cpu_defines_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              div_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] opa_i,
    input  logic [DATA_W-1:0] opb_i,
    input  logic              flush_i,
    input  logic              hi_we_i,
    input  logic              lo_we_i,
    input  logic [DATA_W-1:0] hilo_wdata_i,
    output logic              busy_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output md_state_e         state_o
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    md_state_e           state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    // MUL: running product. DIV: {remainder, dividend/quotient}.
    logic [2*DATA_W-1:0] acc_q, acc_d;
    // MUL: multiplicand, shifted left each step. DIV: divisor in low half.
    logic [2*DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic                div_q, div_d;
    logic                neg_lo_q, neg_lo_d;  // negate product / quotient
    logic                neg_hi_q, neg_hi_d;  // negate remainder
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;

    logic [DATA_W-1:0]   abs_a, abs_b;
    logic                sign_diff;
    logic [DATA_W:0]     trial;
    logic [2*DATA_W-1:0] acc_neg;
    logic [DATA_W-1:0]   rem_neg, quo_neg;

    assign abs_a     = (signed_i && opa_i[DATA_W-1]) ? -opa_i : opa_i;
    assign abs_b     = (signed_i && opb_i[DATA_W-1]) ? -opb_i : opb_i;
    assign sign_diff = signed_i && (opa_i[DATA_W-1] ^ opb_i[DATA_W-1]);
    // Partial remainder shifted left with the next dividend bit, minus divisor.
    assign trial     = acc_q[2*DATA_W-1:DATA_W-1] - {1'b0, mcand_q[DATA_W-1:0]};
    assign acc_neg   = -acc_q;
    assign rem_neg   = -acc_q[2*DATA_W-1:DATA_W];
    assign quo_neg   = -acc_q[DATA_W-1:0];

    assign hi_o    = hi_q;
    assign lo_o    = lo_q;
    assign state_o = state_q;

    // Next-state and datapath step for the mul/div sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        div_d    = div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_o   = 1'b0;

        if (hi_we_i) hi_d = hilo_wdata_i;
        if (lo_we_i) lo_d = hilo_wdata_i;

        case (state_q)
            MD_IDLE: begin
                if (start_i) begin
                    busy_o = 1'b1;
                    cnt_d  = '0;
                    div_d  = div_i;
                    if (div_i) begin
                        if (opb_i == '0) begin
                            // Divide by zero: HI = dividend, LO = all ones.
                            acc_d    = {opa_i, {DATA_W{1'b1}}};
                            neg_lo_d = 1'b0;
                            neg_hi_d = 1'b0;
                            state_d  = MD_DONE;
                        end else begin
                            acc_d    = {{DATA_W{1'b0}}, abs_a};
                            mcand_d  = {{DATA_W{1'b0}}, abs_b};
                            neg_lo_d = sign_diff;
                            neg_hi_d = signed_i && opa_i[DATA_W-1];
                            state_d  = MD_DIV;
                        end
                    end else begin
                        acc_d    = '0;
                        mcand_d  = {{DATA_W{1'b0}}, abs_a};
                        mplier_d = abs_b;
                        neg_lo_d = sign_diff;
                        neg_hi_d = 1'b0;
                        state_d  = MD_MUL;
                    end
                end
            end
            MD_MUL: begin
                busy_o = 1'b1;
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = MD_DONE;
                end
            end
            MD_DIV: begin
                busy_o = 1'b1;
                if (!trial[DATA_W]) begin
                    acc_d = {trial[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
                end else begin
                    acc_d = {acc_q[2*DATA_W-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = MD_DONE;
                end
            end
            MD_DONE: begin
                // Apply signs and commit to HI/LO on the exit edge.
                state_d = MD_IDLE;
                cnt_d   = '0;
                if (div_q) begin
                    hi_d = neg_hi_q ? rem_neg : acc_q[2*DATA_W-1:DATA_W];
                    lo_d = neg_lo_q ? quo_neg : acc_q[DATA_W-1:0];
                end else begin
                    hi_d = neg_lo_q ? acc_neg[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
                    lo_d = neg_lo_q ? acc_neg[DATA_W-1:0] : acc_q[DATA_W-1:0];
                end
            end
            default: begin
                state_d = MD_IDLE;
            end
        endcase

        // Flush abandons the op from any state without touching HI/LO.
        if (flush_i) begin
            state_d = MD_IDLE;
            cnt_d   = '0;
            hi_d    = hi_q;
            lo_d    = lo_q;
            busy_o  = 1'b0;
        end
    end

    // State, counter, datapath and HI/LO registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            div_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            div_q    <= div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

endmodule

// File: rtl/ex_mdu.sv
// Execute stage: combinational logic/shift/arithmetic/move ops, result
// select and write-enable, plus the iterative mul/div unit holding HI/LO.
// stallreq_o holds the upstream stages while a mul/div op is in flight;
// upstream keeps every input stable for as long as it is high.
module ex_mdu
    import cpu_defines_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  AluSelBus              alusel_i,
    input  AluOpBus               aluop_i,
    input  logic [DATA_W-1:0]     reg1_i,
    input  logic [DATA_W-1:0]     reg2_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic                  flush_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [DATA_W-1:0]     wdata_o,
    output logic                  stallreq_o,
    output logic [DATA_W-1:0]     hi_o,
    output logic [DATA_W-1:0]     lo_o,
    output md_state_e             mdu_state_o
);

    localparam int SH_W = $clog2(DATA_W);
    localparam int MSB  = DATA_W - 1;

    logic [SH_W-1:0]   shamt;
    logic [DATA_W-1:0] sum, diff;
    logic              slt, sltu, ovf;
    logic [DATA_W-1:0] logic_res, shift_res, arith_res, move_res, result;

    logic              md_start, md_div, md_signed, md_busy;
    logic              hi_we, lo_we;

    assign shamt = reg1_i[SH_W-1:0];
    assign sum   = reg1_i + reg2_i;
    assign diff  = reg1_i - reg2_i;
    assign slt   = $signed(reg1_i) < $signed(reg2_i);
    assign sltu  = reg1_i < reg2_i;

    // Per-class results and signed overflow detection.
    always_comb begin
        logic_res = ZeroWord[DATA_W-1:0];
        shift_res = ZeroWord[DATA_W-1:0];
        arith_res = ZeroWord[DATA_W-1:0];
        move_res  = ZeroWord[DATA_W-1:0];
        ovf       = 1'b0;
        case (aluop_i)
            OP_OR:   logic_res = reg1_i | reg2_i;
            OP_AND:  logic_res = reg1_i & reg2_i;
            OP_XOR:  logic_res = reg1_i ^ reg2_i;
            OP_NOR:  logic_res = ~(reg1_i | reg2_i);
            OP_SLL:  shift_res = reg2_i << shamt;
            OP_SRL:  shift_res = reg2_i >> shamt;
            OP_SRA:  shift_res = $signed(reg2_i) >>> shamt;
            OP_ADD: begin
                arith_res = sum;
                ovf = (reg1_i[MSB] == reg2_i[MSB]) && (sum[MSB] != reg1_i[MSB]);
            end
            OP_ADDU: arith_res = sum;
            OP_SUB: begin
                arith_res = diff;
                ovf = (reg1_i[MSB] != reg2_i[MSB]) && (diff[MSB] != reg1_i[MSB]);
            end
            OP_SUBU: arith_res = diff;
            OP_SLT:  arith_res = {{(DATA_W-1){1'b0}}, slt};
            OP_SLTU: arith_res = {{(DATA_W-1){1'b0}}, sltu};
            OP_MFHI: move_res  = hi_o;
            OP_MFLO: move_res  = lo_o;
            default: ;
        endcase
    end

    // Result select by class; unknown selects give zero.
    always_comb begin
        result = ZeroWord[DATA_W-1:0];
        case (alusel_i)
            SEL_LOGIC: result = logic_res;
            SEL_SHIFT: result = shift_res;
            SEL_ARITH: result = arith_res;
            SEL_MOVE:  result = move_res;
            default:   result = ZeroWord[DATA_W-1:0];
        endcase
    end

    assign md_start  = is_muldiv(aluop_i);
    assign md_div    = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
    assign md_signed = (aluop_i == OP_MULT) || (aluop_i == OP_DIV);

    // MTHI/MTLO commit only when the stage actually advances.
    assign hi_we = rst && (aluop_i == OP_MTHI) && !stallreq_o && !flush_i;
    assign lo_we = rst && (aluop_i == OP_MTLO) && !stallreq_o && !flush_i;

    mdu_iter #(
        .DATA_W (DATA_W)
    ) u_mdu (
        .clk          (clk),
        .rst          (rst),
        .start_i      (md_start),
        .div_i        (md_div),
        .signed_i     (md_signed),
        .opa_i        (reg1_i),
        .opb_i        (reg2_i),
        .flush_i      (flush_i),
        .hi_we_i      (hi_we),
        .lo_we_i      (lo_we),
        .hilo_wdata_i (reg1_i),
        .busy_o       (md_busy),
        .hi_o         (hi_o),
        .lo_o         (lo_o),
        .state_o      (mdu_state_o)
    );

    // All pipeline-facing outputs are forced quiet while reset is held.
    assign stallreq_o = rst && md_busy;
    assign wreg_o     = rst && wreg_i && !stallreq_o && !ovf;
    assign wdata_o    = rst ? result : ZeroWord[DATA_W-1:0];
    assign wd_o       = rst ? wd_i : '0;

endmodule

// File: tb/tb_ex_mdu.sv
// Bench for ex_mdu: table of single-cycle vectors, then hand-written
// mul/div, MTHI/MTLO, flush and mid-op reset sequences.
module tb_ex_mdu;
  import cpu_defines_pkg::*;

  localparam int W  = 32;
  localparam int AW = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  AluSelBus          alusel;
  AluOpBus           aluop;
  logic [W-1:0]      reg1, reg2;
  logic [AW-1:0]     wd_in;
  logic              wreg_in, flush;
  logic [AW-1:0]     wd_o;
  logic              wreg_o, stallreq_o;
  logic [W-1:0]      wdata_o, hi_o, lo_o;
  md_state_e         dbg_state;

  ex_mdu #(.DATA_W(W), .REG_ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .alusel_i    (alusel),
    .aluop_i     (aluop),
    .reg1_i      (reg1),
    .reg2_i      (reg2),
    .wd_i        (wd_in),
    .wreg_i      (wreg_in),
    .flush_i     (flush),
    .wd_o        (wd_o),
    .wreg_o      (wreg_o),
    .wdata_o     (wdata_o),
    .stallreq_o  (stallreq_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o),
    .mdu_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] cur_hi = '0;
  logic [W-1:0] cur_lo = '0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input AluSelBus sel, input AluOpBus op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [AW-1:0] wd, input logic wr);
    alusel  = sel;
    aluop   = op;
    reg1    = a;
    reg2    = b;
    wd_in   = wd;
    wreg_in = wr;
  endtask

  // Reference HI/LO and stall length for a mul/div op.
  task automatic md_model(input AluOpBus op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] eh, output logic [W-1:0] el, output int st);
    longint sa, sb, p, q, r;
    bit sgn;
    sgn = (op == OP_MULT) || (op == OP_DIV);
    sa  = sgn ? longint'($signed(a)) : longint'(a);
    sb  = sgn ? longint'($signed(b)) : longint'(b);
    if (op == OP_MULT || op == OP_MULTU) begin
      p  = sa * sb;
      eh = p[63:32];
      el = p[31:0];
      st = W + 1;
    end else if (b == '0) begin
      eh = a;
      el = '1;
      st = 1;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      eh = r[31:0];
      el = q[31:0];
      st = W + 1;
    end
  endtask

  // Issue a mul/div op, count stall cycles, then read back via MFHI/MFLO.
  task automatic run_md(input string tag, input AluOpBus op, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    logic [W-1:0] eh, el;
    int exp_st, st;
    md_model(op, a, b, eh, el, exp_st);
    exp_q.push_back(eh);
    exp_q.push_back(el);
    @(negedge clk);
    drive(SEL_NOP, op, a, b, 5'd0, 1'b0);
    #1;
    st = 0;
    for (int i = 0; i < 100 && stallreq_o; i++) begin
      st++;
      @(negedge clk);
      #1;
    end
    chk({tag, "_stall_cycles"}, st, exp_st);
    chk({tag, "_done_state"}, 32'(dbg_state), 32'(MD_DONE));
    @(negedge clk);
    drive(SEL_MOVE, OP_MFHI, '0, '0, 5'd2, 1'b1);
    #1;
    chk({tag, "_hi"}, hi_o, exp_q.pop_front());
    chk({tag, "_mfhi"}, wdata_o, eh);
    @(negedge clk);
    drive(SEL_MOVE, OP_MFLO, '0, '0, 5'd3, 1'b1);
    #1;
    chk({tag, "_lo"}, lo_o, exp_q.pop_front());
    chk({tag, "_mflo"}, wdata_o, el);
    cur_hi = eh;
    cur_lo = el;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    AluSelBus     sel;
    AluOpBus      op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] data;
    logic         wreg;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{SEL_LOGIC, OP_OR,   32'hF0F00000, 32'h00000F0F, 32'hF0F00F0F, 1'b1};
    vecs[1]  = '{SEL_LOGIC, OP_AND,  32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b1};
    vecs[2]  = '{SEL_LOGIC, OP_XOR,  32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b1};
    vecs[3]  = '{SEL_LOGIC, OP_NOR,  32'h0000FFFF, 32'h00FF0000, 32'hFF000000, 1'b1};
    vecs[4]  = '{SEL_SHIFT, OP_SLL,  32'd31,       32'h00000003, 32'h80000000, 1'b1};
    vecs[5]  = '{SEL_SHIFT, OP_SRL,  32'd4,        32'h80000000, 32'h08000000, 1'b1};
    vecs[6]  = '{SEL_SHIFT, OP_SRA,  32'd4,        32'h80000000, 32'hF8000000, 1'b1};
    vecs[7]  = '{SEL_SHIFT, OP_SRA,  32'h00000024, 32'h80000000, 32'hF8000000, 1'b1};
    vecs[8]  = '{SEL_ARITH, OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0};
    vecs[9]  = '{SEL_ARITH, OP_ADDU, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1};
    vecs[10] = '{SEL_ARITH, OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0};
    vecs[11] = '{SEL_ARITH, OP_SUBU, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b1};
    vecs[12] = '{SEL_ARITH, OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
    vecs[13] = '{SEL_ARITH, OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b1};
    vecs[14] = '{SEL_ARITH, OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
    vecs[15] = '{SEL_NOP,   OP_NOP,  32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1};
    vecs[16] = '{3'd7,      OP_OR,   32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1};
    vecs[17] = '{SEL_MOVE,  OP_MFHI, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1};

    // ---- reset state ----
    rst   = 1'b0;
    flush = 1'b0;
    drive(SEL_ARITH, OP_ADDU, 32'd1, 32'd2, 5'd7, 1'b1);
    #3;
    chk("rst_wd", 32'(wd_o), 32'd0);
    chk("rst_wreg", 32'(wreg_o), 32'd0);
    chk("rst_wdata", wdata_o, 32'd0);
    chk("rst_hi", hi_o, 32'd0);
    chk("rst_lo", lo_o, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(MD_IDLE));
    drive(SEL_NOP, OP_MULT, 32'd3, 32'd4, 5'd0, 1'b0);
    #1;
    chk("rst_stall", 32'(stallreq_o), 32'd0);
    drive(SEL_NOP, OP_NOP, '0, '0, 5'd0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // ---- single-cycle vectors ----
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].sel, vecs[i].op, vecs[i].a, vecs[i].b, AW'(i + 1), 1'b1);
      exp_q.push_back(vecs[i].data);
      #1;
      chk($sformatf("vec%0d_data", i), wdata_o, exp_q.pop_front());
      chk($sformatf("vec%0d_wreg", i), 32'(wreg_o), 32'(vecs[i].wreg));
      chk($sformatf("vec%0d_wd", i), 32'(wd_o), 32'(i + 1));
      chk($sformatf("vec%0d_stall", i), 32'(stallreq_o), 32'd0);
    end

    // ---- MTHI / MTLO then read back ----
    @(negedge clk);
    drive(SEL_MOVE, OP_MTHI, 32'h00001234, '0, 5'd4, 1'b0);
    #1;
    chk("mthi_wreg", 32'(wreg_o), 32'd0);
    chk("mthi_stall", 32'(stallreq_o), 32'd0);
    @(negedge clk);
    drive(SEL_MOVE, OP_MFHI, '0, '0, 5'd4, 1'b1);
    #1;
    chk("mfhi_after_mthi", wdata_o, 32'h00001234);
    @(negedge clk);
    drive(SEL_MOVE, OP_MTLO, 32'h0000ABCD, '0, 5'd4, 1'b0);
    @(negedge clk);
    drive(SEL_MOVE, OP_MFLO, '0, '0, 5'd4, 1'b1);
    #1;
    chk("mflo_after_mtlo", wdata_o, 32'h0000ABCD);
    chk("mtlo_hi_kept", hi_o, 32'h00001234);

    // ---- mul/div corner cases ----
    run_md("mult_neg", OP_MULT, 32'hFFFFFFFE, 32'd3);
    run_md("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2);
    run_md("divu_zero", OP_DIVU, 32'd5, 32'd0);
    run_md("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_md("div_negdiv", OP_DIV, 32'd7, 32'hFFFFFFFE);
    run_md("div_zero_s", OP_DIV, 32'hFFFFFFF0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      AluOpBus rop;
      logic [W-1:0] ra, rb;
      case ($urandom_range(0, 3))
        0: rop = OP_MULT;
        1: rop = OP_MULTU;
        2: rop = OP_DIV;
        default: rop = OP_DIVU;
      endcase
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      run_md($sformatf("rand%0d", i), rop, ra, rb);
    end

    // ---- flush at MULT iteration 10 ----
    @(negedge clk);
    drive(SEL_NOP, OP_MULT, 32'd5, 32'd7, 5'd0, 1'b0);
    for (int i = 0; i < 11; i++) @(negedge clk);
    #1;
    chk("flush_pre_stall", 32'(stallreq_o), 32'd1);
    chk("flush_pre_state", 32'(dbg_state), 32'(MD_MUL));
    flush = 1'b1;
    #1;
    chk("flush_stall", 32'(stallreq_o), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    drive(SEL_NOP, OP_NOP, '0, '0, 5'd0, 1'b0);
    #1;
    chk("flush_state", 32'(dbg_state), 32'(MD_IDLE));
    chk("flush_hi", hi_o, cur_hi);
    chk("flush_lo", lo_o, cur_lo);
    chk("flush_post_stall", 32'(stallreq_o), 32'd0);

    // ---- async reset mid-DIV ----
    @(negedge clk);
    drive(SEL_NOP, OP_DIV, 32'd100, 32'd7, 5'd9, 1'b0);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mrst_wd", 32'(wd_o), 32'd0);
    chk("mrst_wreg", 32'(wreg_o), 32'd0);
    chk("mrst_wdata", wdata_o, 32'd0);
    chk("mrst_stall", 32'(stallreq_o), 32'd0);
    chk("mrst_hi", hi_o, 32'd0);
    chk("mrst_lo", lo_o, 32'd0);
    @(negedge clk);
    drive(SEL_NOP, OP_NOP, '0, '0, 5'd0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mrst_post_state", 32'(dbg_state), 32'(MD_IDLE));
    chk("mrst_post_hi", hi_o, 32'd0);
    chk("mrst_post_lo", lo_o, 32'd0);
    run_md("divu_after_rst", OP_DIVU, 32'd100, 32'd7);

    @(negedge clk);
    drive(SEL_NOP, OP_NOP, '0, '0, 5'd0, 1'b0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mdu.md
# ex_mdu

Parametrised execute stage for the in-order pipeline, between the ID/EX and EX/MEM pipeline registers. It replaces the single-op combinational execute stage with full logic, shift and arithmetic ops plus an iterative multiply/divide unit that owns the HI/LO registers. Multi-cycle ops hold the pipeline through `stallreq_o`. All other results are combinational, as before.

## Interface
- `DATA_W`, 32, datapath width; even, ≥ 8.
- `REG_ADDR_W`, 5, register-file address width.
- `clk` input 1: pipeline clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `alusel_i` input `AluSelBus`: result class (LOGIC, SHIFT, ARITH, MOVE, NOP).
- `aluop_i` input `AluOpBus`: operation code.
- `reg1_i`, `reg2_i` input `DATA_W`: operands. For shifts, `reg1_i[$clog2(DATA_W)-1:0]` is the shift amount and `reg2_i` is the value.
- `wd_i` input `REG_ADDR_W`: destination register.
- `wreg_i` input 1: write-enable request.
- `flush_i` input 1: cancels any in-flight mul/div.
- `wd_o` output `REG_ADDR_W`: equals `wd_i`.
- `wreg_o` output 1: final write enable.
- `wdata_o` output `DATA_W`: result.
- `stallreq_o` output 1: holds the upstream stages.
- `hi_o`, `lo_o` output `DATA_W`: current HI/LO values.

## Operation
- **Single-cycle ops (combinational):**
  - OR, AND, XOR, NOR.
  - SLL, SRL, SRA.
  - ADD, ADDU, SUB, SUBU: modulo 2^DATA_W. Signed ADD/SUB overflow forces `wreg_o`=0.
  - SLT (signed), SLTU (unsigned): result is 1 or 0, zero-extended.
  - MFHI, MFLO: read the HI/LO register value.
  - MTHI, MTLO: write `reg1_i` to HI or LO at the clock edge when `stallreq_o`=0 and `flush_i`=0. Their `wreg_o` is 0.
- **Mul/div FSM: IDLE → MUL | DIV → DONE → IDLE.**
  - IDLE: on MULT/MULTU/DIV/DIVU, latch the magnitudes of the operands (signed ops), the result-sign flags and cnt=0.
    - DIV/DIVU with divisor 0 goes straight to DONE.
  - MUL: radix-2 shift-add, one bit per cycle. cnt increments and the FSM exits to DONE after cnt = DATA_W-1.
  - DIV: restoring division, one quotient bit per cycle, same count.
  - DONE: negate the product (MULT), quotient or remainder (DIV) as needed. Remainder takes the dividend's sign; quotient truncates toward zero. Write HI/LO on the exit edge, then return to IDLE.
  - Divide by zero: HI = dividend, LO = all ones.
- `stallreq_o` = 1 in the IDLE issue cycle of a mul/div op and throughout MUL/DIV. It is 0 in DONE, so the pipeline advances on the DONE exit edge.
- Upstream holds all inputs stable while `stallreq_o`=1. DONE never re-issues the still-present op.
- `wreg_o` = `wreg_i` & ~`stallreq_o` & ~overflow. Mul/div ops themselves have `wreg_i`=0.
- `wdata_o` is selected by `alusel_i`; an unknown select gives 0.
- `flush_i` in any state: the FSM goes to IDLE at the next edge, HI/LO are not written, and `stallreq_o` is 0 in that cycle.
- Reset:
  - State = IDLE, HI = LO = 0, cnt = 0, datapath regs = 0.
  - While `rst`=0: `wd_o`=0, `wreg_o`=0, `wdata_o`=0, `stallreq_o`=0.
  - Reset mid-operation discards the op.

## Timing
- Single-cycle ops: zero latency (combinational in to out).
- MULT/DIV with nonzero divisor:
  - Issue cycle t: `stallreq_o`=1 for cycles t .. t+DATA_W, which is DATA_W+1 cycles.
  - DONE at cycle t+DATA_W+1.
  - HI/LO updated at the end of that cycle.
- Divide by zero: stall for 1 cycle (t), DONE at t+1.
- MFHI in the cycle after DONE sees the new value. There is no same-cycle bypass; HI/LO are registered and that is sufficient because DONE is its own cycle.
- Simultaneous MTHI and DONE cannot occur, because MTHI cannot issue while the FSM is in DONE.

## Structure
- Shared package `cpu_defines_pkg`:
  - `AluSelBus` and `AluOpBus` widths and encodings (all ops above).
  - `ZeroWord` generalised to `DATA_W`.
  - The mul/div FSM state typedef.
- One sub-module, `mdu_iter`, holds the FSM, cnt, the iterative mul/div datapath and the HI/LO registers.
  - Ports: start, op, signed flag, operands, flush, busy, hi, lo, and the MTHI/MTLO write port.
- `ex_mdu` holds the combinational ops, the result mux and the write-enable logic.

## Test plan
- SRA with `reg2_i`=0x80000000 and amount 4 → `wdata_o`=0xF8000000. SLT of -1 vs 1 → 1. SLTU of the same operands → 0.
- ADD 0x7FFFFFFF + 1 → `wreg_o`=0. ADDU of the same operands → `wdata_o`=0x80000000, `wreg_o`=1.
- MULT -2 × 3 → `stallreq_o` high for 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. A following MFLO returns 0xFFFFFFFA.
- DIV -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 5 / 0 → 1-cycle stall, HI=5, LO=0xFFFFFFFF.
- MTHI 0x1234 then MFHI on the next cycle → 0x1234.
- Flush at MULT iteration 10 → stall drops, HI/LO unchanged. Async reset mid-DIV → all outputs 0 immediately; after release, HI=LO=0 and IDLE.
